// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR engine.
package fir_pkg;

  localparam int MAX_TAPS = 32;   // coefficient RAM depth / longest filter
  localparam int DATA_W   = 16;   // Q15 sample, coefficient and result width
  localparam int ACC_W    = 38;   // 32-bit products plus growth for 32 taps
  localparam int CNT_W    = 14;   // samples-per-run counter width

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SAMPLE,
    MAC,
    OUTPUT
  } fir_state_t;

endpackage : fir_pkg

// File: rtl/fir_delay_line.sv
// Sample history for the FIR: x[0] holds the newest sample. Supports a
// synchronous clear, a shift-in enable and one combinational indexed read.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int  DEPTH = fir_pkg::MAX_TAPS,
  parameter int  WIDTH = fir_pkg::DATA_W,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    shift_en,
  input  logic signed [WIDTH-1:0] din,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic signed [WIDTH-1:0] rd_data
);

  logic signed [WIDTH-1:0] taps [DEPTH];

  // Shift register with clear; every run must start from an all-zero history.
  // NOTE: this array is cleared on purpose because stale history would leak
  // into the first outputs of a run; plain storage arrays are normally left
  // unreset so they can map onto RAM.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps[i] <= '0;
      end
    end else if (shift_en) begin
      // NOTE: non-blocking assignments let every tap take its neighbour's old
      // value in the same edge; blocking ones would smear x[0] down the line.
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign rd_data = taps[rd_idx];

endmodule : fir_delay_line

// File: rtl/fir_engine.sv
// Sequential single-MAC FIR filter. Coefficients are fetched from an external
// RAM (one-cycle read latency) while a run of Ile_probek samples is processed,
// one input handshake and one output handshake per sample.
module fir_engine
  import fir_pkg::*;
#(
  parameter int  MAX_TAPS = fir_pkg::MAX_TAPS,
  parameter int  DATA_W   = fir_pkg::DATA_W,
  localparam int ADDR_W   = $clog2(MAX_TAPS),
  localparam int WSP_W    = $clog2(MAX_TAPS + 1)
) (
  input  logic                     clk_b,
  input  logic                     rst,
  input  logic                     Start,
  input  logic [WSP_W-1:0]         Ile_wsp,
  input  logic [CNT_W-1:0]         Ile_probek,
  output logic [ADDR_W-1:0]        address_FIR,
  input  logic signed [DATA_W-1:0] wsp_data,
  output logic                     FSM_MUX_CDC,
  output logic                     pracuje,
  output logic                     DONE,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int                  FRAC_W  = DATA_W - 1;
  localparam int                  PROD_W  = 2 * DATA_W;
  localparam logic [DATA_W-1:0]   SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]   SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  fir_state_t state_q, state_d;

  logic                     start_q;
  logic [WSP_W-1:0]         n_q;
  logic [CNT_W-1:0]         probek_q;
  logic [CNT_W-1:0]         smp_cnt_q;
  logic                     done_q;

  logic [WSP_W-1:0]         tap_cnt_q;
  logic [ADDR_W-1:0]        k_q;
  logic                     acc_en_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] out_data_q;

  logic                     start_edge;
  logic                     cfg_ok;
  logic                     load_run;
  logic                     in_fire;
  logic                     out_fire;
  logic                     last_sample;
  logic                     tap_active;
  logic                     mac_last;

  logic signed [DATA_W-1:0] tap_x;
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_shr;
  logic [ACC_W-DATA_W:0]    acc_top;
  logic signed [DATA_W-1:0] sat_data;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  assign start_edge  = Start && !start_q;
  assign cfg_ok      = (Ile_wsp != '0) && (Ile_wsp <= WSP_W'(MAX_TAPS)) &&
                       (Ile_probek != '0);
  assign load_run    = (state_q == IDLE) && start_edge && cfg_ok;
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign last_sample = ((smp_cnt_q + CNT_W'(1)) == probek_q);
  assign tap_active  = (tap_cnt_q < n_q);
  assign mac_last    = (state_q == MAC) && (tap_cnt_q == n_q);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore-style control outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    pracuje     = 1'b1;
    FSM_MUX_CDC = 1'b1;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    address_FIR = '0;

    unique case (state_q)
      IDLE: begin
        pracuje     = 1'b0;
        FSM_MUX_CDC = 1'b0;
        if (load_run) begin
          state_d = WAIT_SAMPLE;
        end
      end

      WAIT_SAMPLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = MAC;
        end
      end

      MAC: begin
        // Addresses run ahead of the accumulate by one cycle (RAM latency);
        // the extra trailing cycle only absorbs the last coefficient.
        if (tap_active) begin
          address_FIR = tap_cnt_q[ADDR_W-1:0];
        end
        if (mac_last) begin
          state_d = OUTPUT;
        end
      end

      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = last_sample ? IDLE : WAIT_SAMPLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run control
  // ---------------------------------------------------------------------------

  // Start edge detector, latched run configuration, sample counter and DONE.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      // Tracking Start during reset means a level held through reset is not
      // seen as a fresh edge afterwards.
      start_q   <= Start;
      n_q       <= '0;
      probek_q  <= '0;
      smp_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      start_q <= Start;
      done_q  <= 1'b0;
      if ((state_q == IDLE) && start_edge) begin
        if (cfg_ok) begin
          n_q       <= Ile_wsp;
          probek_q  <= Ile_probek;
          smp_cnt_q <= '0;
        end else begin
          // Rejected request: report completion without ever going busy.
          done_q <= 1'b1;
        end
      end
      if (out_fire) begin
        smp_cnt_q <= smp_cnt_q + CNT_W'(1);
        if (last_sample) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  fir_delay_line #(
    .DEPTH (MAX_TAPS),
    .WIDTH (DATA_W)
  ) u_delay_line (
    .clk      (clk_b),
    .clr      (rst || load_run),
    .shift_en (in_fire),
    .din      (in_data),
    .rd_idx   (k_q),
    .rd_data  (tap_x)
  );

  assign product = wsp_data * tap_x;
  assign acc_sum = acc_q + ACC_W'(product);
  assign acc_shr = acc_sum >>> FRAC_W;
  assign acc_top = acc_shr[ACC_W-1:DATA_W-1];

  // Q15 rescale by truncation, then clamp anything outside the 16-bit range.
  always_comb begin
    if (!acc_shr[ACC_W-1] && (|acc_top)) begin
      sat_data = SAT_MAX;
    end else if (acc_shr[ACC_W-1] && !(&acc_top)) begin
      sat_data = SAT_MIN;
    end else begin
      sat_data = acc_shr[DATA_W-1:0];
    end
  end

  // Tap counter, delayed tap index, accumulator and held output sample.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      tap_cnt_q  <= '0;
      k_q        <= '0;
      acc_en_q   <= 1'b0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      // Delayed copies line the delay-line index up with the RAM read data.
      acc_en_q <= (state_q == MAC) && tap_active;
      k_q      <= tap_cnt_q[ADDR_W-1:0];
      if (in_fire) begin
        acc_q     <= '0;
        tap_cnt_q <= '0;
      end else if (state_q == MAC) begin
        if (!mac_last) begin
          tap_cnt_q <= tap_cnt_q + WSP_W'(1);
        end
        if (acc_en_q) begin
          acc_q <= acc_sum;
        end
        if (mac_last) begin
          out_data_q <= sat_data;
        end
      end
    end
  end

  assign out_data = out_data_q;
  assign DONE     = done_q;

endmodule : fir_engine

// File: tb/tb_fir_engine.sv
// Self-checking bench for fir_engine: table-driven runs plus hand-written
// sequences for rejected starts, output back-pressure and reset mid-MAC.
module tb_fir_engine;

  typedef struct packed {
    logic [15:0] sample;
    logic [15:0] expected;
  } vec_t;

  logic        clk_b = 1'b0;
  logic        rst;
  logic        Start;
  logic [5:0]  Ile_wsp;
  logic [13:0] Ile_probek;
  logic [4:0]  address_FIR;
  logic [15:0] wsp_data;
  logic        FSM_MUX_CDC;
  logic        pracuje;
  logic        DONE;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [15:0] coef_mem [32];
  logic signed [15:0] model_x  [32];
  int                 model_n;
  logic [15:0]        sb_q [$];
  vec_t               job_v [$];
  logic [15:0]        last_out;

  always #5 clk_b = ~clk_b;

  // Coefficient RAM model: read data valid one cycle after the address.
  always @(posedge clk_b) wsp_data <= coef_mem[address_FIR];

  fir_engine dut (
    .clk_b       (clk_b),
    .rst         (rst),
    .Start       (Start),
    .Ile_wsp     (Ile_wsp),
    .Ile_probek  (Ile_probek),
    .address_FIR (address_FIR),
    .wsp_data    (wsp_data),
    .FSM_MUX_CDC (FSM_MUX_CDC),
    .pracuje     (pracuje),
    .DONE        (DONE),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_b);
    #1;
  endtask

  // Reference filter: 64-bit exact sum, arithmetic shift, clamp to Q15.
  function automatic logic [15:0] model_push(input logic [15:0] s);
    longint acc;
    for (int k = 31; k > 0; k--) model_x[k] = model_x[k-1];
    model_x[0] = s;
    acc = 0;
    for (int k = 0; k < model_n; k++) acc += longint'(coef_mem[k]) * longint'(model_x[k]);
    acc = acc >>> 15;
    if (acc > 64'sd32767)  return 16'h7FFF;
    if (acc < -64'sd32768) return 16'h8000;
    return 16'(acc);
  endfunction

  // One complete run over job_v; stall_idx selects a sample whose output is
  // back-pressured for 10 cycles (-1 for none).
  task automatic run_job(input int n_taps, input bit use_model, input int stall_idx);
    int          n_samp;
    int          lat;
    int          guard;
    bit          addr_ok, ir_ok, hold_ok, idle_ok;
    logic [15:0] exp_v, d0;
    n_samp  = job_v.size();
    model_n = n_taps;
    for (int k = 0; k < 32; k++) model_x[k] = '0;
    Ile_wsp    = 6'(n_taps);
    Ile_probek = 14'(n_samp);
    Start = 1'b0;
    step();
    Start = 1'b1;
    step();
    check("busy_after_start", pracuje, 1);
    check("mux_after_start", FSM_MUX_CDC, 1);
    // Configuration changes mid-run must be ignored.
    Ile_wsp    = 6'd0;
    Ile_probek = 14'd1;
    for (int i = 0; i < n_samp; i++) begin
      repeat ($urandom_range(0, 2)) step();
      guard = 0;
      while (!in_ready && guard < 50) begin
        step();
        guard++;
      end
      check("in_ready_wait", in_ready, 1);
      in_valid = 1'b1;
      in_data  = job_v[i].sample;
      exp_v    = model_push(job_v[i].sample);
      if (!use_model) exp_v = job_v[i].expected;
      sb_q.push_back(exp_v);
      out_ready = (i != stall_idx);
      step();
      in_valid = 1'b0;
      in_data  = '0;
      lat = 1; addr_ok = 1'b1; ir_ok = 1'b1;
      while (!out_valid && lat < 100) begin
        if (address_FIR !== 5'((lat <= n_taps) ? lat - 1 : 0)) addr_ok = 1'b0;
        if (in_ready !== 1'b0) ir_ok = 1'b0;
        step();
        lat++;
      end
      check("out_latency", lat, n_taps + 2);
      check("addr_sequence", addr_ok, 1);
      check("in_ready_low_busy", ir_ok, 1);
      if (i == stall_idx) begin
        d0 = out_data;
        hold_ok = 1'b1;
        for (int j = 0; j < 10; j++) begin
          step();
          if (out_data !== d0 || in_ready !== 1'b0 || out_valid !== 1'b1) hold_ok = 1'b0;
        end
        check("stall_hold", hold_ok, 1);
        out_ready = 1'b1;
      end
      check("out_data", out_data, sb_q.pop_front());
      last_out = out_data;
      step();
      if (i == n_samp - 1) begin
        check("done_pulse", DONE, 1);
        check("idle_after_run", pracuje, 0);
        check("mux_after_run", FSM_MUX_CDC, 0);
        step();
        check("done_single", DONE, 0);
      end else begin
        check("no_early_done", DONE, 0);
        check("back_to_wait", in_ready, 1);
      end
    end
    // Start is still high: no further run may begin.
    idle_ok = 1'b1;
    repeat (5) begin
      step();
      if (pracuje !== 1'b0) idle_ok = 1'b0;
    end
    check("start_level_no_rerun", idle_ok, 1);
    Start = 1'b0;
  endtask

  task automatic bad_start(input string name, input int wsp, input int prb);
    bit ok;
    Ile_wsp    = 6'(wsp);
    Ile_probek = 14'(prb);
    Start = 1'b0;
    step();
    Start = 1'b1;
    step();
    check({name, "_done"}, DONE, 1);
    check({name, "_busy"}, pracuje, 0);
    ok = 1'b1;
    repeat (8) begin
      step();
      if (pracuje !== 1'b0 || DONE !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
    end
    check({name, "_stay_idle"}, ok, 1);
    Start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int k = 0; k < 32; k++) coef_mem[k] = '0;
    rst = 1'b1; Start = 1'b1; Ile_wsp = '0; Ile_probek = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    check("rst_pracuje", pracuje, 0);
    check("rst_mux", FSM_MUX_CDC, 0);
    check("rst_done", DONE, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_addr", address_FIR, 0);
    rst = 1'b0;
    Ile_wsp = 6'd4; Ile_probek = 14'd2;
    ok = 1'b1;
    repeat (4) begin
      step();
      if (pracuje !== 1'b0) ok = 1'b0;
    end
    check("start_held_through_reset", ok, 1);
    Start = 1'b0;

    // Single tap, single sample: 0x2000 * 0x4000 -> 0x1000.
    coef_mem[0] = 16'sh4000;
    job_v = '{'{16'h2000, 16'h1000}};
    run_job(1, 1'b0, -1);

    // Four taps, impulse response, with a 10-cycle output stall on sample 2.
    coef_mem[0] = 16'sd100; coef_mem[1] = 16'sd200;
    coef_mem[2] = 16'sd300; coef_mem[3] = 16'sd400;
    job_v = '{'{16'h4000, 16'd50}, '{16'h0000, 16'd100}, '{16'h0000, 16'd150},
              '{16'h0000, 16'd200}, '{16'h0000, 16'd0}};
    run_job(4, 1'b0, 2);

    // Full-length filter driven into both saturation limits.
    for (int k = 0; k < 32; k++) coef_mem[k] = 16'sh7FFF;
    job_v.delete();
    for (int i = 0; i < 32; i++) job_v.push_back('{16'h7FFF, 16'h0000});
    run_job(32, 1'b1, -1);
    check("sat_pos_last", last_out, 16'h7FFF);
    job_v.delete();
    for (int i = 0; i < 32; i++) job_v.push_back('{16'h8000, 16'h0000});
    run_job(32, 1'b1, -1);
    check("sat_neg_last", last_out, 16'h8000);

    // Random coefficients and samples, seven taps.
    for (int k = 0; k < 32; k++) coef_mem[k] = 16'($urandom);
    job_v.delete();
    for (int i = 0; i < 12; i++) job_v.push_back('{16'($urandom), 16'h0000});
    run_job(7, 1'b1, 5);

    // Rejected start requests.
    bad_start("wsp_zero", 0, 3);
    bad_start("wsp_too_big", 33, 3);
    bad_start("probek_zero", 4, 0);

    // Reset in the middle of MAC, then a clean run from an empty history.
    for (int k = 0; k < 8; k++) coef_mem[k] = 16'sh1000;
    Ile_wsp = 6'd8; Ile_probek = 14'd2;
    Start = 1'b0;
    step();
    Start = 1'b1;
    step();
    check("mid_mac_wait_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 16'h7000;
    step();
    in_valid = 1'b0;
    in_data  = '0;
    step();
    step();
    check("mid_mac_addr", address_FIR, 2);
    check("mid_mac_busy", pracuje, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_pracuje", pracuje, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_mux", FSM_MUX_CDC, 0);
    check("abort_addr", address_FIR, 0);
    check("abort_out_data", out_data, 0);
    ok = 1'b1;
    repeat (4) begin
      step();
      if (pracuje !== 1'b0 || DONE !== 1'b0) ok = 1'b0;
    end
    check("abort_stays_idle", ok, 1);
    Start = 1'b0;
    coef_mem[0] = 16'sd100; coef_mem[1] = 16'sd200;
    coef_mem[2] = 16'sd300; coef_mem[3] = 16'sd400;
    job_v = '{'{16'h4000, 16'd50}, '{16'h0000, 16'd100}};
    run_job(4, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fir_engine
